// File: rtl/ph_reg.sv
// Product-high register for a shift-and-add multiplier datapath.
// Holds the upper half of the partial product. It either loads the adder sum
// in parallel or shifts right, with the adder carry entering the MSB.
// lsb is the serial link into the product-low register.
// Optional feature: define PH_SOUT_EN to add a registered sout port that
// captures the bit shifted out of qph[0] on each taken shift.
module ph_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             sft,
  input  logic             carry,
  input  logic [WIDTH-1:0] dph,
  output logic [WIDTH-1:0] qph,
  output logic             lsb,
  output logic             zero
`ifdef PH_SOUT_EN
  ,
  output logic             sout
`endif
);

  // Register update: async clear, then load has priority over shift, else hold
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      qph <= '0;
    end else if (load) begin
      qph <= dph;
    end else if (sft) begin
      qph <= {carry, qph[WIDTH-1:1]};
    end
  end

`ifdef PH_SOUT_EN
  // Shifted-out bit capture: old LSB on a taken shift, zero on load or clear
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sout <= 1'b0;
    end else if (load) begin
      sout <= 1'b0;
    end else if (sft) begin
      sout <= qph[0];
    end
  end
`endif

  assign lsb  = qph[0];
  assign zero = (qph == '0);

endmodule

// File: tb/tb_ph_reg.sv
// Self-checking bench for ph_reg (WIDTH = 4), table-driven synchronous steps
// plus hand-written sequences for reset and mid-cycle asynchronous clear.
module tb_ph_reg;

  localparam int WIDTH = 4;
  localparam int NVEC  = 15;

  typedef struct {
    string            name;
    logic             load;
    logic             sft;
    logic             carry;
    logic [WIDTH-1:0] dph;
    logic [WIDTH-1:0] exp_q;
    logic             exp_sout;
  } vec_t;

  logic             clk;
  logic             clr;
  logic             load;
  logic             sft;
  logic             carry;
  logic [WIDTH-1:0] dph;
  logic [WIDTH-1:0] qph;
  logic             lsb;
  logic             zero;
`ifdef PH_SOUT_EN
  logic             sout;
`endif

  int   total;
  int   bad;
  vec_t vecs [NVEC];

  ph_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clr   (clr),
    .load  (load),
    .sft   (sft),
    .carry (carry),
    .dph   (dph),
    .qph   (qph),
    .lsb   (lsb),
    .zero  (zero)
`ifdef PH_SOUT_EN
    ,
    .sout  (sout)
`endif
  );

  // Free-running clock, first rising edge at t=5
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input vec_t v);
    load  = v.load;
    sft   = v.sft;
    carry = v.carry;
    dph   = v.dph;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_q,
                             input logic exp_sout);
    logic exp_zero;
    exp_zero = (exp_q == 4'b0000);
    total++;
    if (qph !== exp_q) begin
      bad++;
      $display("[TB] FAIL %s qph: got %b expected %b", name, qph, exp_q);
    end
    total++;
    if (lsb !== exp_q[0]) begin
      bad++;
      $display("[TB] FAIL %s lsb: got %b expected %b", name, lsb, exp_q[0]);
    end
    total++;
    if (zero !== exp_zero) begin
      bad++;
      $display("[TB] FAIL %s zero: got %b expected %b", name, zero, exp_zero);
    end
`ifdef PH_SOUT_EN
    total++;
    if (sout !== exp_sout) begin
      bad++;
      $display("[TB] FAIL %s sout: got %b expected %b", name, sout, exp_sout);
    end
`else
    if (exp_sout === 1'bx) $display("[TB] note: %s has no sout expectation", name);
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //           name          load  sft   carry dph      exp_q    exp_sout
    vecs[0]  = '{"load_1011",  1'b1, 1'b0, 1'b0, 4'b1011, 4'b1011, 1'b0};
    vecs[1]  = '{"hold_1011",  1'b0, 1'b0, 1'b1, 4'b0000, 4'b1011, 1'b0};
    vecs[2]  = '{"shc1_a",     1'b0, 1'b1, 1'b1, 4'b0000, 4'b1101, 1'b1};
    vecs[3]  = '{"shc1_b",     1'b0, 1'b1, 1'b1, 4'b0000, 4'b1110, 1'b1};
    vecs[4]  = '{"shc1_c",     1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0};
    vecs[5]  = '{"reload",     1'b1, 1'b0, 1'b0, 4'b1011, 4'b1011, 1'b0};
    vecs[6]  = '{"shc0_a",     1'b0, 1'b1, 1'b0, 4'b1111, 4'b0101, 1'b1};
    vecs[7]  = '{"shc0_b",     1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010, 1'b1};
    vecs[8]  = '{"shc0_c",     1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 1'b0};
    vecs[9]  = '{"shc0_d",     1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1};
    vecs[10] = '{"load_1111",  1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0};
    vecs[11] = '{"ld_beats_sh",1'b1, 1'b1, 1'b1, 4'b0110, 4'b0110, 1'b0};
    vecs[12] = '{"hold_0110",  1'b0, 1'b0, 1'b1, 4'b1001, 4'b0110, 1'b0};
    vecs[13] = '{"sh_0110",    1'b0, 1'b1, 1'b1, 4'b0000, 4'b1011, 1'b0};
    vecs[14] = '{"load_1111b", 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0};

    // Reset asserted at time zero, checked before any clock edge
    clr   = 1'b1;
    load  = 1'b0;
    sft   = 1'b0;
    carry = 1'b1;
    dph   = 4'b1011;
    #1;
    checkOutput("reset_t0", 4'b0000, 1'b0);

    // Clear held high overrides load and shift across clock edges
    load = 1'b1;
    sft  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("clr_held", 4'b0000, 1'b0);

    // Release clear on a falling edge; table drives the following edges
    @(negedge clk);
    clr  = 1'b0;
    load = 1'b0;
    sft  = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkOutput(vecs[i].name, vecs[i].exp_q, vecs[i].exp_sout);
    end

    // Asynchronous clear mid-cycle while a shift is pending from 1111
    @(negedge clk);
    load  = 1'b0;
    sft   = 1'b1;
    carry = 1'b1;
    #2;
    clr = 1'b1;
    #1;
    checkOutput("async_clr", 4'b0000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("async_clr_held", 4'b0000, 1'b0);

    // Release with shift and carry=1: next edge inserts carry into MSB
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_clr_shift", 4'b1000, 1'b0);

    // Mid-cycle toggles of load between edges do not change the register
    @(negedge clk);
    sft  = 1'b0;
    dph  = 4'b0101;
    load = 1'b1;
    #1;
    load = 1'b0;
    #1;
    checkOutput("midcycle_load", 4'b1000, 1'b0);
    @(posedge clk); #1;
    checkOutput("midcycle_hold", 4'b1000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ph_reg.md
Name: ph_reg

Overview:
- Product-high (PH) register for a shift-and-add multiplier datapath.
- Holds the upper half of the partial product.
- Loads the adder sum in parallel, or shifts right with the adder carry entering the MSB.
- The LSB feeds the product-low register's shift input.

Parameters:
WIDTH, 4, register width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-high reset/clear of the register
load  input  1  synchronous parallel load of dph
sft  input  1  synchronous logical right shift with carry insertion
carry  input  1  bit shifted into the MSB during a shift (adder carry-out)
dph  input  WIDTH  parallel load data (adder sum)
qph  output  WIDTH  current register contents
lsb  output  1  combinational copy of qph[0]; serial link to the PL register
zero  output  1  combinational, high when qph == 0

Behaviour:
- One clock; reset is asynchronous and active-high (clk, clr).
- clr asserted: qph = 0 immediately, without waiting for a clock edge. This also makes lsb = 0 and zero = 1.
- clr held high: qph stays 0 regardless of load/sft/clock activity.
- Clear release is synchronous-safe: the first rising edge after clr falls evaluates load/sft normally.
- Priority on each rising clk edge, clr low:
  - load = 1: qph <= dph.
  - else sft = 1: qph <= {carry, qph[WIDTH-1:1]}.
  - else: hold.
- load and sft both high: load wins, no shift occurs.
- Shift is logical with carry fill, not arithmetic sign extension. The old qph[0] is discarded, unless the optional feature captures it.
- Latency: one clock from control sample to qph update. No internal state other than qph (plus sout when the optional feature is enabled).
- Inputs are sampled only on the rising edge; mid-cycle toggles have no effect except on clr.
- lsb and zero are purely combinational from qph.
- No X propagation from unused inputs: dph is ignored unless load = 1, and carry is ignored unless the shift is taken.

Optional Feature:
Macro: PH_SOUT_EN
- Defined:
  - Adds output port sout (1 bit, registered).
  - On every taken shift, sout <= old qph[0].
  - On load, sout <= 0.
  - On clr, sout = 0 asynchronously.
  - Otherwise sout holds.
- Undefined:
  - Port sout does not exist.
  - The shifted-out bit is discarded.
  - All other behaviour is identical.

Test Plan:
- Reset: clr = 1 at time 0 with load = 0, sft = 0, carry = 1, dph = 1011 -> qph = 0000, zero = 1, lsb = 0 before any clock edge.
- Load: clr = 0, load = 1 for one edge, dph = 1011 -> qph = 1011, lsb = 1, zero = 0; with load = 0, sft = 0 afterwards, qph holds 1011.
- Shift with carry = 1: sft = 1 for three edges starting from 1011 -> qph = 1101, 1110, 1111. With PH_SOUT_EN, sout = 1, 1, 0 after the successive shifts.
- Shift with carry = 0 from 1011 for four edges -> 0101, 0010, 0001, 0000; zero = 1 after the fourth shift.
- Priority: load = 1 and sft = 1 together, dph = 0110, qph = 1111 -> qph = 0110 (load wins).
- Async clear mid-operation: qph = 1111, sft = 1, assert clr between edges -> qph = 0000 immediately; stays 0 while clr is high; after release with sft = 1 and carry = 1, the next edge gives 1000.
